// File: rtl/twin_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : twin_reg_pkg
//  Brief    : Shared types and constants for the twin register serial path.
//  Revision : 1.0 - initial release
// ============================================================================
package twin_reg_pkg;

   // Word width of each register in the twin set and the resulting frame.
   localparam int TWIN_WIDTH     = 8;
   localparam int TWIN_FRAME_LEN = 2 * TWIN_WIDTH;

   // Transmitter state encoding, kept as plain constants for older tools.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_DONE  = 2'd2;

endpackage : twin_reg_pkg
`default_nettype wire

// File: rtl/twin_reg_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : twin_reg_serial_tx
//  Brief    : Captures both twin register words on a start request and shifts
//             them out one bit per clock with a frame strobe, a busy flag and
//             a one-cycle completion pulse. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module twin_reg_serial_tx
   import twin_reg_pkg::*;
#(
   parameter int WIDTH     = TWIN_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic             sdo,
   output logic             frame,
   output logic             busy,
   output logic             done
);

   localparam int                c_FRAME_LEN = 2 * WIDTH;
   localparam int                c_CNT_W     = $clog2(c_FRAME_LEN);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_FRAME_LEN - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   state_t                   r_state;
   logic [c_CNT_W-1:0]       r_cnt;
   logic [c_FRAME_LEN-1:0]   r_shift;
   logic                     r_sdo;
   logic                     r_frame;
   logic                     r_busy;
   logic                     r_done;
   logic [c_FRAME_LEN-1:0]   w_stream;

   // Arrange both words in transmit order so the MSB of w_stream goes first.
   always_comb begin
      w_stream = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (MSB_FIRST) begin
            w_stream[c_FRAME_LEN-1-i] = d1[WIDTH-1-i];
            w_stream[WIDTH-1-i]       = d2[WIDTH-1-i];
         end else begin
            w_stream[c_FRAME_LEN-1-i] = d1[i];
            w_stream[WIDTH-1-i]       = d2[i];
         end
      end
   end

   // Frame FSM: the first bit is registered straight from the capture so it
   // appears one cycle after start; the counter tracks the bit now on sdo.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_sdo   <= 1'b0;
         r_frame <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= ST_SHIFT;
                  r_cnt   <= '0;
                  r_sdo   <= w_stream[c_FRAME_LEN-1];
                  r_shift <= {w_stream[c_FRAME_LEN-2:0], 1'b0};
                  r_frame <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (r_cnt == c_CNT_LAST) begin
                  r_state <= ST_DONE;
                  r_sdo   <= 1'b0;
                  r_frame <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + c_CNT_ONE;
                  r_sdo   <= r_shift[c_FRAME_LEN-1];
                  r_shift <= {r_shift[c_FRAME_LEN-2:0], 1'b0};
               end
            end
            ST_DONE: begin
               // Start is ignored here, giving the fixed frame spacing.
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_sdo   <= 1'b0;
               r_frame <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign sdo   = r_sdo;
   assign frame = r_frame;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule : twin_reg_serial_tx
`default_nettype wire

// File: tb/tb_twin_reg_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_twin_reg_serial_tx
//  Brief    : Scoreboard bench for twin_reg_serial_tx, one MSB-first and one
//             LSB-first instance driven by the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_twin_reg_serial_tx;

   localparam int W      = 8;
   localparam int FLEN   = 2 * W;
   localparam int SPACING = FLEN + 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] d1;
   logic [W-1:0] d2;
   logic         sdo_m, frame_m, busy_m, done_m;
   logic         sdo_l, frame_l, busy_l, done_l;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int acc   = -1000;
   bit q_m[$];
   bit q_l[$];

   twin_reg_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .start(start), .d1(d1), .d2(d2),
      .sdo(sdo_m), .frame(frame_m), .busy(busy_m), .done(done_m)
   );

   twin_reg_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .start(start), .d1(d1), .d2(d2),
      .sdo(sdo_l), .frame(frame_l), .busy(busy_l), .done(done_l)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: a start is taken when at least SPACING cycles have
   // passed since the last taken start; the expected bit stream is queued.
   always @(posedge clk) begin
      cyc++;
      if (rst !== 1'b1 && start === 1'b1 && (cyc - acc) >= SPACING) begin
         acc = cyc;
         for (int i = W - 1; i >= 0; i--) q_m.push_back(d1[i]);
         for (int i = W - 1; i >= 0; i--) q_m.push_back(d2[i]);
         for (int i = 0; i < W; i++)      q_l.push_back(d1[i]);
         for (int i = 0; i < W; i++)      q_l.push_back(d2[i]);
      end
   end

   // Reset aborts any frame in flight.
   always @(posedge rst) begin
      acc = -1000;
      q_m.delete();
      q_l.delete();
   end

   // Monitor: compare control outputs against the frame window and pop a
   // data bit whenever a DUT shows frame high.
   always @(negedge clk) begin
      int k;
      bit b;
      k = cyc - acc;
      chk("msb_frame", int'(frame_m), int'(k >= 0 && k < FLEN));
      chk("msb_busy",  int'(busy_m),  int'(k >= 0 && k <= FLEN));
      chk("msb_done",  int'(done_m),  int'(k == FLEN));
      chk("lsb_frame", int'(frame_l), int'(k >= 0 && k < FLEN));
      chk("lsb_busy",  int'(busy_l),  int'(k >= 0 && k <= FLEN));
      chk("lsb_done",  int'(done_l),  int'(k == FLEN));
      if (frame_m === 1'b1) begin
         if (q_m.size() == 0) chk("msb_sdo_underflow", 1, 0);
         else begin b = q_m.pop_front(); chk("msb_sdo", int'(sdo_m), int'(b)); end
      end else chk("msb_sdo_idle", int'(sdo_m), 0);
      if (frame_l === 1'b1) begin
         if (q_l.size() == 0) chk("lsb_sdo_underflow", 1, 0);
         else begin b = q_l.pop_front(); chk("lsb_sdo", int'(sdo_l), int'(b)); end
      end else chk("lsb_sdo_idle", int'(sdo_l), 0);
   end

   task automatic drive(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = s;
      d1    = a;
      d2    = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, d1, d2);
   endtask

   // Assert reset between edges and confirm outputs clear without a clock.
   task automatic mid_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_sdo",   int'(sdo_m | sdo_l),     0);
      chk("rst_async_frame", int'(frame_m | frame_l), 0);
      chk("rst_async_busy",  int'(busy_m | busy_l),   0);
      chk("rst_async_done",  int'(done_m | done_l),   0);
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      d1    = '0;
      d2    = '0;
      repeat (3) @(negedge clk);
      chk("reset_sdo",   int'(sdo_m),   0);
      chk("reset_frame", int'(frame_m), 0);
      chk("reset_busy",  int'(busy_m),  0);
      chk("reset_done",  int'(done_m),  0);
      rst = 1'b0;
      idle(2);

      // Basic frame: 17/33 (also the LSB-first instance sees it).
      drive(1'b1, 8'd17, 8'd33);
      idle(20);
      // LSB-first reference pattern 1/10.
      drive(1'b1, 8'd1, 8'd10);
      idle(20);

      // Start held high: one frame per SPACING cycles, d2 changes mid-frame.
      drive(1'b1, 8'd21, 8'd99);
      for (int i = 0; i < 3 * SPACING; i++)
         drive(1'b1, 8'd21, (i == 5) ? 8'd16 : d2);
      idle(20);

      // Reset after 5 bits, then a fresh FF/00 frame.
      drive(1'b1, 8'hA5, 8'h5A);
      idle(4);
      mid_reset();
      idle(2);
      drive(1'b1, 8'hFF, 8'h00);
      idle(20);

      // Back-to-back at exactly the minimum spacing.
      drive(1'b1, 8'h3C, 8'hC3);
      idle(SPACING - 1);
      drive(1'b1, 8'h81, 8'h7E);
      idle(SPACING + 2);

      // Randomized traffic with occasional mid-frame reset.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 149) == 0) mid_reset();
         else drive($urandom_range(0, 3) == 0, W'($urandom), W'($urandom));
      end
      idle(SPACING + 4);

      chk("msb_queue_empty", q_m.size(), 0);
      chk("lsb_queue_empty", q_l.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_twin_reg_serial_tx
`default_nettype wire
